// File: rtl/riscv_v_csr_regfile.sv
// Vector CSR storage (vsstatus, vtype, vl, vstart, vxrm, vxsat): applies write side effects and tracks in-flight writes.
// Optional feature: define RISCV_V_CSR_BYPASS_EN to forward same-cycle exe writes to the ID outputs.
module riscv_v_csr_regfile #(
    parameter int unsigned RISCV_V_ID_2_EXE_LATENCY = 2,
    parameter int unsigned MAX_VL                   = 256,
    parameter int unsigned MAX_VSEW                 = 3,
    parameter int unsigned PIPE_LATENCY             = RISCV_V_ID_2_EXE_LATENCY,
    parameter int unsigned RISCV_V_VSSTATUS_WIDTH   = 32,
    parameter int unsigned RISCV_V_VTYPE_WIDTH      = 32,
    parameter int unsigned RISCV_V_VL_WIDTH         = 32,
    parameter int unsigned RISCV_V_VSTART_WIDTH     = 16,
    parameter int unsigned RISCV_V_VXRM_WIDTH       = 2,
    parameter int unsigned RISCV_V_VXSAT_WIDTH      = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic                              flush,
    input  logic                              wr_req_vsstatus_id,
    input  logic                              wr_req_vtype_id,
    input  logic                              wr_req_vl_id,
    input  logic                              wr_req_vstart_id,
    input  logic                              wr_req_vxrm_id,
    input  logic                              wr_req_vxsat_id,
    input  logic                              csr_wr_en_vsstatus_exe,
    input  logic                              csr_wr_en_vtype_exe,
    input  logic                              csr_wr_en_vl_exe,
    input  logic                              csr_wr_en_vstart_exe,
    input  logic                              csr_wr_en_vxrm_exe,
    input  logic                              csr_wr_en_vxsat_exe,
    input  logic [RISCV_V_VSSTATUS_WIDTH-1:0] csr_wr_data_vsstatus_exe,
    input  logic [RISCV_V_VTYPE_WIDTH-1:0]    csr_wr_data_vtype_exe,
    input  logic [RISCV_V_VL_WIDTH-1:0]       csr_wr_data_vl_exe,
    input  logic [RISCV_V_VSTART_WIDTH-1:0]   csr_wr_data_vstart_exe,
    input  logic [RISCV_V_VXRM_WIDTH-1:0]     csr_wr_data_vxrm_exe,
    input  logic [RISCV_V_VXSAT_WIDTH-1:0]    csr_wr_data_vxsat_exe,
    input  logic                              vec_instr_done_exe,
    input  logic                              vec_sat_exe,
    output logic [RISCV_V_VSSTATUS_WIDTH-1:0] vsstatus_id,
    output logic [RISCV_V_VTYPE_WIDTH-1:0]    vtype_id,
    output logic [RISCV_V_VL_WIDTH-1:0]       vl_id,
    output logic [RISCV_V_VSTART_WIDTH-1:0]   vstart_id,
    output logic [RISCV_V_VXRM_WIDTH-1:0]     vxrm_id,
    output logic [RISCV_V_VXSAT_WIDTH-1:0]    vxsat_id,
    output logic                              csr_busy_vsstatus,
    output logic                              csr_busy_vtype,
    output logic                              csr_busy_vl,
    output logic                              csr_busy_vstart,
    output logic                              csr_busy_vxrm,
    output logic                              csr_busy_vxsat
);

    localparam int unsigned VT_W    = RISCV_V_VTYPE_WIDTH;
    localparam int unsigned VL_W    = RISCV_V_VL_WIDTH;
    localparam int unsigned VXSAT_W = RISCV_V_VXSAT_WIDTH;
    localparam int unsigned NUM_CSR = 6;
    localparam int unsigned CNT_W   = $clog2(PIPE_LATENCY + 2);

    localparam logic [VT_W-1:0]  VTYPE_VILL = VT_W'(1) << (VT_W - 1);
    localparam logic [2:0]       MAX_VSEW_C = 3'(MAX_VSEW);
    localparam logic [VL_W-1:0]  MAX_VL_C   = VL_W'(MAX_VL);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [RISCV_V_VSSTATUS_WIDTH-1:0] vsstatus_q, vsstatus_d;
    logic [VT_W-1:0]                   vtype_q, vtype_d;
    logic [VL_W-1:0]                   vl_q, vl_d;
    logic [RISCV_V_VSTART_WIDTH-1:0]   vstart_q, vstart_d;
    logic [RISCV_V_VXRM_WIDTH-1:0]     vxrm_q, vxrm_d;
    logic [VXSAT_W-1:0]                vxsat_q, vxsat_d;
    logic                              vtype_illegal;

    // vill is read-only, so a written bit 31 counts as a reserved bit like bits [30:8].
    always_comb begin
        // NOTE: every combinational output is given a default first so no path can infer a latch.
        vtype_illegal = (csr_wr_data_vtype_exe[5:3] > MAX_VSEW_C)
                     || (csr_wr_data_vtype_exe[2:0] == 3'b100)
                     || (csr_wr_data_vtype_exe[VT_W-1:8] != '0);
        vsstatus_d = vsstatus_q;
        vtype_d    = vtype_q;
        vl_d       = vl_q;
        vstart_d   = vstart_q;
        vxrm_d     = vxrm_q;
        vxsat_d    = vxsat_q;

        if (csr_wr_en_vsstatus_exe) vsstatus_d = csr_wr_data_vsstatus_exe;
        if (csr_wr_en_vxrm_exe)     vxrm_d     = csr_wr_data_vxrm_exe;

        if (csr_wr_en_vl_exe)
            vl_d = (csr_wr_data_vl_exe > MAX_VL_C) ? MAX_VL_C : csr_wr_data_vl_exe;

        if (csr_wr_en_vtype_exe) begin
            if (vtype_illegal) begin
                vtype_d = VTYPE_VILL;
                vl_d    = '0;
            end else begin
                vtype_d = csr_wr_data_vtype_exe;
            end
        end

        if (csr_wr_en_vstart_exe)    vstart_d = csr_wr_data_vstart_exe;
        else if (vec_instr_done_exe) vstart_d = '0;

        vxsat_d = (csr_wr_en_vxsat_exe ? csr_wr_data_vxsat_exe : vxsat_q) | VXSAT_W'(vec_sat_exe);
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsstatus_q <= '0;
            vtype_q    <= VTYPE_VILL;
            vl_q       <= '0;
            vstart_q   <= '0;
            vxrm_q     <= '0;
            vxsat_q    <= '0;
        end else begin
            vsstatus_q <= vsstatus_d;
            vtype_q    <= vtype_d;
            vl_q       <= vl_d;
            vstart_q   <= vstart_d;
            vxrm_q     <= vxrm_d;
            vxsat_q    <= vxsat_d;
        end
    end

`ifdef RISCV_V_CSR_BYPASS_EN
    assign vsstatus_id = (csr_wr_en_vsstatus_exe && !rst) ? vsstatus_d : vsstatus_q;
    assign vtype_id    = (csr_wr_en_vtype_exe    && !rst) ? vtype_d    : vtype_q;
    assign vl_id       = (csr_wr_en_vl_exe       && !rst) ? vl_d       : vl_q;
    assign vstart_id   = (csr_wr_en_vstart_exe   && !rst) ? vstart_d   : vstart_q;
    assign vxrm_id     = (csr_wr_en_vxrm_exe     && !rst) ? vxrm_d     : vxrm_q;
    assign vxsat_id    = (csr_wr_en_vxsat_exe    && !rst) ? vxsat_d    : vxsat_q;
`else
    assign vsstatus_id = vsstatus_q;
    assign vtype_id    = vtype_q;
    assign vl_id       = vl_q;
    assign vstart_id   = vstart_q;
    assign vxrm_id     = vxrm_q;
    assign vxsat_id    = vxsat_q;
`endif

    logic [NUM_CSR-1:0] req, inc, dec, busy;

    assign req = {wr_req_vxsat_id, wr_req_vxrm_id, wr_req_vstart_id,
                  wr_req_vl_id, wr_req_vtype_id, wr_req_vsstatus_id};
    assign dec = {csr_wr_en_vxsat_exe, csr_wr_en_vxrm_exe, csr_wr_en_vstart_exe,
                  csr_wr_en_vl_exe, csr_wr_en_vtype_exe, csr_wr_en_vsstatus_exe};
    assign inc = req & {NUM_CSR{~stall & ~flush}};

    for (genvar g = 0; g < NUM_CSR; g++) begin : g_track
        logic [CNT_W-1:0] cnt_q;

        // Out-of-range steps hold the counter; the assertions below flag them.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_q <= '0;
            else if (flush)
                cnt_q <= '0;
            else if (inc[g] && !dec[g] && (cnt_q != CNT_MAX))
                cnt_q <= cnt_q + 1'b1;
            else if (dec[g] && !inc[g] && (cnt_q != '0))
                cnt_q <= cnt_q - 1'b1;
        end

`ifdef RISCV_V_CSR_BYPASS_EN
        assign busy[g] = (cnt_q != '0) && !((cnt_q == CNT_W'(1)) && dec[g] && !inc[g]);
`else
        assign busy[g] = (cnt_q != '0);
`endif

        a_no_underflow: assert property (@(posedge clk) disable iff (rst)
            !(dec[g] && !inc[g] && !flush && (cnt_q == '0)));
        a_no_overflow: assert property (@(posedge clk) disable iff (rst)
            !(inc[g] && !dec[g] && (cnt_q == CNT_MAX)));
    end

    assign csr_busy_vsstatus = busy[0];
    assign csr_busy_vtype    = busy[1];
    assign csr_busy_vl       = busy[2];
    assign csr_busy_vstart   = busy[3];
    assign csr_busy_vxrm     = busy[4];
    assign csr_busy_vxsat    = busy[5];

endmodule
